// File: rtl/note_spawner.sv
// Scrolling 4-lane note field: spawns a random row at the top on each scroll
// step and shifts the field one row toward the judgment line.
module note_spawner #(
  parameter int STEP_CYC = 2500000,
  parameter int ROWS     = 8,
  parameter int GAP      = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic              i_Stop,
  input  logic              i_Pause,
  input  logic [7:0]        i_Rand,
  input  logic [3:0]        i_Density,
  output logic [4*ROWS-1:0] o_Field,
  output logic [3:0]        o_Bottom,
  output logic              o_Step,
  output logic              o_Spawn,
  output logic [15:0]       o_NoteCnt,
  output logic              o_Running
);
  localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 1);
  localparam logic [GW-1:0] GAP_V = GW'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

  state_e                state_q, state_d;
  logic [ROWS-1:0][3:0]  field_q, field_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         cool_q, cool_d;
  logic                  step_q, step_d;
  logic                  spawn_q, spawn_d;
  logic [15:0]           ncnt_q, ncnt_d;

  logic [3:0]  pat;
  logic        do_spawn;
  logic [2:0]  pop;
  logic [16:0] nsum;

  assign pat      = i_Rand[7:4];
  assign do_spawn = (cool_q == '0) && (i_Rand[3:0] < i_Density) && (pat != 4'd0);
  assign pop      = 3'(pat[0]) + 3'(pat[1]) + 3'(pat[2]) + 3'(pat[3]);
  assign nsum     = {1'b0, ncnt_q} + 17'(pop);

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    cnt_d   = cnt_q;
    cool_d  = cool_q;
    ncnt_d  = ncnt_q;
    step_d  = 1'b0;
    spawn_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_Start && !i_Stop) begin
          state_d = S_RUN;
          field_d = '0;
          cool_d  = '0;
          ncnt_d  = '0;
        end
      end
      S_RUN: begin
        if (i_Stop) begin
          state_d = S_IDLE;
          field_d = '0;
          cnt_d   = '0;
          cool_d  = '0;
        end else begin
          // The RUN cycle that samples i_Pause still counts; PAUSE itself holds.
          if (i_Pause) state_d = S_PAUSE;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            step_d  = 1'b1;
            spawn_d = do_spawn;
            field_d = {field_q[ROWS-2:0], (do_spawn ? pat : 4'd0)};
            if (do_spawn) begin
              cool_d = GAP_V;
              ncnt_d = nsum[16] ? 16'hFFFF : nsum[15:0];
            end else if (cool_q != '0) begin
              cool_d = cool_q - 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (i_Stop) begin
          state_d = S_IDLE;
          field_d = '0;
          cnt_d   = '0;
          cool_d  = '0;
        end else if (!i_Pause) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= S_IDLE;
      field_q <= '0;
      cnt_q   <= '0;
      cool_q  <= '0;
      step_q  <= 1'b0;
      spawn_q <= 1'b0;
      ncnt_q  <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      step_q  <= step_d;
      spawn_q <= spawn_d;
      ncnt_q  <= ncnt_d;
    end
  end

  assign o_Field   = field_q;
  assign o_Bottom  = field_q[ROWS-1];
  assign o_Step    = step_q;
  assign o_Spawn   = spawn_q;
  assign o_NoteCnt = ncnt_q;
  assign o_Running = (state_q != S_IDLE);
endmodule

// File: tb/tb_note_spawner.sv
// Bench for note_spawner: cycle-by-cycle reference model plus boundary table
// and hand-written pause / stop / async-reset sequences.
module tb_note_spawner;
  localparam int STEP_CYC = 4;
  localparam int ROWS     = 4;
  localparam int GAP      = 1;

  logic              i_Clk = 1'b0;
  logic              i_Rst = 1'b0;
  logic              i_Start = 1'b0, i_Stop = 1'b0, i_Pause = 1'b0;
  logic [7:0]        i_Rand = 8'h00;
  logic [3:0]        i_Density = 4'd4;
  logic [4*ROWS-1:0] o_Field;
  logic [3:0]        o_Bottom;
  logic              o_Step, o_Spawn, o_Running;
  logic [15:0]       o_NoteCnt;

  note_spawner #(.STEP_CYC(STEP_CYC), .ROWS(ROWS), .GAP(GAP)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Stop(i_Stop),
    .i_Pause(i_Pause), .i_Rand(i_Rand), .i_Density(i_Density),
    .o_Field(o_Field), .o_Bottom(o_Bottom), .o_Step(o_Step),
    .o_Spawn(o_Spawn), .o_NoteCnt(o_NoteCnt), .o_Running(o_Running)
  );

  always #5 i_Clk = ~i_Clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: 0 idle, 1 run, 2 pause; phase = RUN cycles since last step.
  int m_state, m_phase, m_cool, m_notes;
  int m_rows[ROWS];
  bit m_step, m_spawn;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  task automatic model_clear_field();
    for (int r = 0; r < ROWS; r++) m_rows[r] = 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_cool = 0; m_notes = 0;
    m_step = 0; m_spawn = 0;
    model_clear_field();
  endtask

  task automatic model_step();
    int pat, prob;
    bit sp;
    pat  = int'(i_Rand[7:4]);
    prob = int'(i_Rand[3:0]);
    sp   = (m_cool == 0) && (prob < int'(i_Density)) && (pat != 0);
    for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
    m_rows[0] = sp ? pat : 0;
    if (sp) begin
      m_cool  = GAP;
      m_notes = m_notes + $countones(i_Rand[7:4]);
      if (m_notes > 65535) m_notes = 65535;
    end else if (m_cool > 0) begin
      m_cool--;
    end
    m_step  = 1;
    m_spawn = sp;
  endtask

  task automatic model_edge();
    m_step = 0; m_spawn = 0;
    if (!i_Rst) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (i_Start && !i_Stop) begin
           m_state = 1; m_phase = 0; m_cool = 0; m_notes = 0;
           model_clear_field();
         end
      1: if (i_Stop) begin
           m_state = 0; m_phase = 0; m_cool = 0;
           model_clear_field();
         end else begin
           m_phase++;
           if (m_phase == STEP_CYC) begin
             m_phase = 0;
             model_step();
           end
           if (i_Pause) m_state = 2;
         end
      default: if (i_Stop) begin
           m_state = 0; m_phase = 0; m_cool = 0;
           model_clear_field();
         end else if (!i_Pause) begin
           m_state = 1;
         end
    endcase
  endtask

  task automatic compare_all(string tag);
    logic [4*ROWS-1:0] f;
    for (int r = 0; r < ROWS; r++) f[4*r +: 4] = 4'(m_rows[r]);
    check({tag, "_field"},   32'(o_Field),   32'(f));
    check({tag, "_bottom"},  32'(o_Bottom),  32'(m_rows[ROWS-1]));
    check({tag, "_step"},    32'(o_Step),    32'(m_step));
    check({tag, "_spawn"},   32'(o_Spawn),   32'(m_spawn));
    check({tag, "_notecnt"}, 32'(o_NoteCnt), 32'(m_notes));
    check({tag, "_running"}, 32'(o_Running), 32'(m_state != 0));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge i_Clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic cycn(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic restart(logic [7:0] rnd, logic [3:0] dens);
    i_Stop = 1'b1; cyc(); i_Stop = 1'b0;
    i_Rand = rnd; i_Density = dens;
    i_Start = 1'b1; cyc(); i_Start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] rnd;
    logic [3:0] dens;
    int         spawns;
    int         notes;
  } bvec_t;

  bvec_t bt[5];

  initial begin
    bt[0] = '{rnd: 8'hA3, dens: 4'd0,  spawns: 0, notes: 0};
    bt[1] = '{rnd: 8'h03, dens: 4'd4,  spawns: 0, notes: 0};
    bt[2] = '{rnd: 8'hFF, dens: 4'd15, spawns: 0, notes: 0};
    bt[3] = '{rnd: 8'hFE, dens: 4'd15, spawns: 5, notes: 20};
    bt[4] = '{rnd: 8'hA3, dens: 4'd4,  spawns: 5, notes: 10};

    // Reset and idle
    model_reset();
    repeat (2) @(posedge i_Clk);
    #1;
    compare_all("reset");
    i_Rst = 1'b1;
    cycn(8);

    // Start with A3 held: spawn, cooldown, spawn, then scroll to the bottom
    i_Rand = 8'hA3; i_Density = 4'd4;
    i_Start = 1'b1; cyc(); i_Start = 1'b0;
    cycn(3);
    check("pre_step1_step", 32'(o_Step), 32'd0);
    cyc();
    check("s1_row0", 32'(o_Field[3:0]), 32'hA);
    check("s1_spawn", 32'(o_Spawn), 32'd1);
    check("s1_notes", 32'(o_NoteCnt), 32'd2);
    cycn(4);
    check("s2_row0", 32'(o_Field[3:0]), 32'h0);
    check("s2_row1", 32'(o_Field[7:4]), 32'hA);
    check("s2_spawn", 32'(o_Spawn), 32'd0);
    cycn(4);
    check("s3_row0", 32'(o_Field[3:0]), 32'hA);
    check("s3_notes", 32'(o_NoteCnt), 32'd4);
    cycn(4);
    check("s4_bottom", 32'(o_Bottom), 32'hA);
    cycn(4);
    check("s5_bottom", 32'(o_Bottom), 32'h0);

    // Boundary table: 10 steps each
    foreach (bt[k]) begin
      int cnt;
      restart(bt[k].rnd, bt[k].dens);
      cnt = 0;
      for (int c = 0; c < 10 * STEP_CYC; c++) begin
        cyc();
        if (o_Spawn) cnt++;
      end
      check($sformatf("tbl%0d_spawns", k), 32'(cnt), 32'(bt[k].spawns));
      check($sformatf("tbl%0d_notes", k), 32'(o_NoteCnt), 32'(bt[k].notes));
    end

    // Pause with the counter at 2
    begin
      logic [4*ROWS-1:0] saved;
      restart(8'hA3, 4'd4);
      cycn(2);
      saved = o_Field;
      i_Pause = 1'b1;
      cycn(7);
      check("pause_field", 32'(o_Field), 32'(saved));
      check("pause_running", 32'(o_Running), 32'd1);
      i_Pause = 1'b0;
      cyc();
      check("resume_1_step", 32'(o_Step), 32'd0);
      cyc();
      check("resume_2_step", 32'(o_Step), 32'd1);
    end

    // Stop and start together while running
    cycn(5);
    i_Stop = 1'b1; i_Start = 1'b1;
    cyc();
    i_Stop = 1'b0; i_Start = 1'b0;
    check("stop_running", 32'(o_Running), 32'd0);
    check("stop_field", 32'(o_Field), 32'd0);
    cycn(3);

    // Async reset right after a step edge
    restart(8'hA3, 4'd4);
    cycn(4);
    check("prerst_step", 32'(o_Step), 32'd1);
    #2;
    i_Rst = 1'b0;
    #1;
    model_reset();
    check("arst_field", 32'(o_Field), 32'd0);
    check("arst_step", 32'(o_Step), 32'd0);
    check("arst_spawn", 32'(o_Spawn), 32'd0);
    check("arst_notes", 32'(o_NoteCnt), 32'd0);
    check("arst_running", 32'(o_Running), 32'd0);
    cycn(2);
    i_Rst = 1'b1;
    cycn(2);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_Rand    = 8'($urandom);
      i_Density = 4'($urandom);
      i_Pause   = ($urandom_range(0, 7) == 0);
      i_Stop    = ($urandom_range(0, 63) == 0);
      i_Start   = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
